gas_alarm_controller: RTL and testbench
=======================================

GAS_ALARM_CONTROLLER -- requirements
Module: gas_alarm_controller

Interface
REQ-001 Parameter WARN_LEVEL, default 3: gas_level threshold (inclusive) for WARN.
REQ-002 Parameter DANGER_LEVEL, default 6: gas_level threshold (inclusive) for ALARM; SHALL exceed WARN_LEVEL.
REQ-003 Parameter CONFIRM_CYCLES, default 4: consecutive at-or-above-threshold samples required to escalate.
REQ-004 Parameter CLEAR_CYCLES, default 16: consecutive below-WARN_LEVEL samples required to de-escalate.
REQ-005 Parameter TEST_CYCLES, default 8: buzzer self-test duration.
REQ-006 clk  input  1  system clock; all state changes on rising edge.
REQ-007 arst  input  1  reset; synchronous, active-high.
REQ-008 gas_level  input  3  level from the gas detector sensor, sampled every cycle.
REQ-009 ack  input  1  user acknowledge, one-cycle pulse or level.
REQ-010 test_req  input  1  buzzer self-test request.
REQ-011 alarm_state  output  2  current state: 0 MONITOR, 1 WARN, 2 ALARM, 3 TEST.
REQ-012 fan_on  output  1  ventilation fan command.
REQ-013 valve_close  output  1  gas valve shut-off command.
REQ-014 buzzer  output  1  audible alarm.
REQ-015 alarm_count  output  8  number of ALARM entries since reset, saturating at 255.

Function
REQ-016 warn_cnt SHALL increment each cycle gas_level >= WARN_LEVEL, clear otherwise, saturate at CONFIRM_CYCLES; danger_cnt likewise for DANGER_LEVEL; clear_cnt counts gas_level < WARN_LEVEL, saturating at CLEAR_CYCLES.
REQ-017 Outputs SHALL be Moore-decoded from the state register: MONITOR all 0; WARN fan_on; ALARM fan_on, valve_close, buzzer (until silenced); TEST buzzer only.
REQ-018 MONITOR -> ALARM at the edge where danger_cnt reaches CONFIRM_CYCLES; else -> WARN where warn_cnt reaches CONFIRM_CYCLES; else -> TEST if test_req=1.
REQ-019 WARN -> ALARM when danger_cnt reaches CONFIRM_CYCLES; WARN -> MONITOR when clear_cnt reaches CLEAR_CYCLES.
REQ-020 ALARM is latched: ack=1 SHALL set a silenced flag (buzzer=0 next cycle) while fan_on and valve_close remain 1.
REQ-021 ALARM -> MONITOR only when silenced=1 and clear_cnt = CLEAR_CYCLES; ack and clear may occur in either order; silenced clears on exit.
REQ-022 TEST SHALL last exactly TEST_CYCLES cycles then -> MONITOR; any gas_level >= WARN_LEVEL sample SHALL abort TEST to MONITOR next edge without resetting warn/danger counters.
REQ-023 test_req SHALL be ignored in WARN and ALARM; ack SHALL be ignored outside ALARM.
REQ-024 alarm_count SHALL increment on each transition into ALARM, saturating at 255.
REQ-025 Escalation latency: gas_level held at DANGER_LEVEL from cycle n gives alarm_state=2 after edge n+CONFIRM_CYCLES-1.
REQ-026 Escalation SHALL take priority over test_req when both qualify in the same cycle.

Reset
REQ-027 arst=1 at a clock edge SHALL force MONITOR, all counters 0, silenced 0, alarm_count 0, all command outputs 0; arst mid-ALARM drops valve_close the next cycle.

Structure
REQ-028 State encodings and default thresholds SHALL live in shared package gas_ctrl_pkg.
REQ-029 A sub-module persist_counter (threshold compare, saturating consecutive count, full flag) SHALL be instantiated three times for warn, danger and clear.

Verification
REQ-030 gas_level=4 for 4 cycles from MONITOR -> alarm_state=1, fan_on=1; then 0 for 16 cycles -> alarm_state=0, fan_on=0.
REQ-031 gas_level=7 for 3 cycles then 0 -> no transition; for 4 cycles -> alarm_state=2, valve_close=1, buzzer=1, alarm_count=1.
REQ-032 In ALARM with gas_level=7, ack pulse -> buzzer=0, valve_close=1, state stays 2; then gas_level=0 for 16 cycles -> state 0.
REQ-033 test_req in MONITOR -> buzzer=1 for exactly 8 cycles; repeat with gas_level=5 in cycle 3 -> state 0 next cycle.
REQ-034 arst=1 during ALARM -> next edge all outputs 0, alarm_count=0.
REQ-035 Alternating gas_level 7/0 each cycle for 40 cycles -> state stays 0, alarm_count stays 0.

Source files
------------

// File: rtl/gas_ctrl_pkg.sv
// Shared state encoding, default thresholds and small helpers for the gas alarm controller.
package gas_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_WARN    = 2'd1,
    ST_ALARM   = 2'd2,
    ST_TEST    = 2'd3
  } alarm_state_e;

  localparam int GAS_W   = 3;
  localparam int COUNT_W = 8;

  localparam int DEF_WARN_LEVEL     = 3;
  localparam int DEF_DANGER_LEVEL   = 6;
  localparam int DEF_CONFIRM_CYCLES = 4;
  localparam int DEF_CLEAR_CYCLES   = 16;
  localparam int DEF_TEST_CYCLES    = 8;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/persist_counter.sv
// Consecutive-sample persistence counter: compares the level against a threshold,
// counts matching samples in a row (saturating) and flags when the count is full.
module persist_counter
  import gas_ctrl_pkg::*;
#(
  parameter int THRESH = DEF_WARN_LEVEL,
  parameter int LIMIT  = DEF_CONFIRM_CYCLES,
  parameter bit BELOW  = 1'b0
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [GAS_W-1:0] i_level,
  output logic             o_full
);

  localparam int            CW  = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);
  localparam logic [GAS_W-1:0] THR = GAS_W'(THRESH);

  logic          w_hit;
  logic [CW-1:0] w_next;
  logic [CW-1:0] r_cnt;

  assign w_hit = BELOW ? (i_level < THR) : (i_level >= THR);

  always_comb begin
    w_next = '0;
    if (w_hit) begin
      w_next = (r_cnt == LIM) ? LIM : r_cnt + CW'(1);
    end
  end

  // Full is taken from the next count so the owner can act on the very edge it is reached.
  assign o_full = (w_next == LIM);

  always_ff @(posedge clk) begin
    if (arst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

endmodule

// File: rtl/gas_alarm_controller.sv
// Gas alarm controller: escalates MONITOR/WARN/ALARM on persistent gas readings,
// latches ALARM until acknowledged and cleared, and runs a timed buzzer self-test.
module gas_alarm_controller
  import gas_ctrl_pkg::*;
#(
  parameter int WARN_LEVEL     = DEF_WARN_LEVEL,
  parameter int DANGER_LEVEL   = DEF_DANGER_LEVEL,
  parameter int CONFIRM_CYCLES = DEF_CONFIRM_CYCLES,
  parameter int CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
  parameter int TEST_CYCLES    = DEF_TEST_CYCLES
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [GAS_W-1:0]   gas_level,
  input  logic               ack,
  input  logic               test_req,
  output logic [1:0]         alarm_state,
  output logic               fan_on,
  output logic               valve_close,
  output logic               buzzer,
  output logic [COUNT_W-1:0] alarm_count
);

  localparam int               TW        = $clog2(TEST_CYCLES + 1);
  localparam logic [TW-1:0]    TEST_LAST = TW'(TEST_CYCLES - 1);
  localparam logic [GAS_W-1:0] WARN_THR  = GAS_W'(WARN_LEVEL);

  alarm_state_e       r_state;
  alarm_state_e       w_next_state;
  logic               r_silenced;
  logic [TW-1:0]      r_test_cnt;
  logic [COUNT_W-1:0] r_alarm_count;
  logic               w_warn_full;
  logic               w_danger_full;
  logic               w_clear_full;
  logic               w_gas_warn;

  persist_counter #(.THRESH(WARN_LEVEL), .LIMIT(CONFIRM_CYCLES), .BELOW(1'b0)) u_warn_cnt (
    .clk     (clk),
    .arst    (arst),
    .i_level (gas_level),
    .o_full  (w_warn_full)
  );

  persist_counter #(.THRESH(DANGER_LEVEL), .LIMIT(CONFIRM_CYCLES), .BELOW(1'b0)) u_danger_cnt (
    .clk     (clk),
    .arst    (arst),
    .i_level (gas_level),
    .o_full  (w_danger_full)
  );

  persist_counter #(.THRESH(WARN_LEVEL), .LIMIT(CLEAR_CYCLES), .BELOW(1'b1)) u_clear_cnt (
    .clk     (clk),
    .arst    (arst),
    .i_level (gas_level),
    .o_full  (w_clear_full)
  );

  assign w_gas_warn = (gas_level >= WARN_THR);

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state <= ST_MONITOR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Danger outranks warn, and both outrank a self-test request.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_MONITOR: begin
        if (w_danger_full)    w_next_state = ST_ALARM;
        else if (w_warn_full) w_next_state = ST_WARN;
        else if (test_req)    w_next_state = ST_TEST;
      end
      ST_WARN: begin
        if (w_danger_full)     w_next_state = ST_ALARM;
        else if (w_clear_full) w_next_state = ST_MONITOR;
      end
      ST_ALARM: begin
        if (r_silenced && w_clear_full) w_next_state = ST_MONITOR;
      end
      ST_TEST: begin
        if (w_gas_warn || (r_test_cnt == TEST_LAST)) w_next_state = ST_MONITOR;
      end
      default: w_next_state = ST_MONITOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_silenced    <= 1'b0;
      r_test_cnt    <= '0;
      r_alarm_count <= '0;
    end else begin
      r_test_cnt <= (r_state == ST_TEST) ? r_test_cnt + 1'b1 : '0;
      if (r_state == ST_ALARM && w_next_state != ST_ALARM) begin
        r_silenced <= 1'b0;
      end else if (r_state == ST_ALARM && ack) begin
        r_silenced <= 1'b1;
      end
      if (w_next_state == ST_ALARM && r_state != ST_ALARM) begin
        r_alarm_count <= sat_inc(r_alarm_count);
      end
    end
  end

  always_comb begin
    fan_on      = 1'b0;
    valve_close = 1'b0;
    buzzer      = 1'b0;
    case (r_state)
      ST_WARN: fan_on = 1'b1;
      ST_ALARM: begin
        fan_on      = 1'b1;
        valve_close = 1'b1;
        buzzer      = ~r_silenced;
      end
      ST_TEST: buzzer = 1'b1;
      default: ;
    endcase
  end

  assign alarm_state = r_state;
  assign alarm_count = r_alarm_count;

endmodule

// File: tb/tb_gas_alarm_controller.sv
// Bench for gas_alarm_controller: vector table, hand-written corner sequences and
// randomized traffic checked against a sample-history reference model.
module tb_gas_alarm_controller;

  localparam int WARN    = 3;
  localparam int DANGER  = 6;
  localparam int CONFIRM = 4;
  localparam int CLEAR   = 16;
  localparam int TESTC   = 8;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [2:0] gas_level = 3'd0;
  logic       ack = 1'b0;
  logic       test_req = 1'b0;
  logic [1:0] alarm_state;
  logic       fan_on, valve_close, buzzer;
  logic [7:0] alarm_count;

  int checks = 0;
  int errors = 0;

  gas_alarm_controller dut (
    .clk         (clk),
    .arst        (arst),
    .gas_level   (gas_level),
    .ack         (ack),
    .test_req    (test_req),
    .alarm_state (alarm_state),
    .fan_on      (fan_on),
    .valve_close (valve_close),
    .buzzer      (buzzer),
    .alarm_count (alarm_count)
  );

  always #5 clk = ~clk;

  // Reference model: decisions come from the recent sample history, not from counters.
  int hist[$];
  int m_st = 0;
  int m_sil = 0;
  int m_cnt = 0;
  int m_tleft = 0;

  function automatic bit run_ok(int n, int thr, bit below);
    if (hist.size() < n) return 1'b0;
    for (int i = hist.size() - n; i < hist.size(); i++) begin
      if (below ? (hist[i] >= thr) : (hist[i] < thr)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input int g, input bit a, input bit t, input bit r);
    bit wf, df, cf;
    int ns;
    if (r) begin
      m_st = 0; m_sil = 0; m_cnt = 0; m_tleft = 0;
      hist.delete();
      return;
    end
    hist.push_back(g);
    if (hist.size() > 64) void'(hist.pop_front());
    wf = run_ok(CONFIRM, WARN, 1'b0);
    df = run_ok(CONFIRM, DANGER, 1'b0);
    cf = run_ok(CLEAR, WARN, 1'b1);
    ns = m_st;
    case (m_st)
      0: begin
        if (df) ns = 2;
        else if (wf) ns = 1;
        else if (t) begin ns = 3; m_tleft = TESTC; end
      end
      1: begin
        if (df) ns = 2;
        else if (cf) ns = 0;
      end
      2: begin
        if (m_sil != 0 && cf) begin ns = 0; m_sil = 0; end
        else if (a) m_sil = 1;
      end
      default: begin
        m_tleft = m_tleft - 1;
        if (g >= WARN || m_tleft == 0) ns = 0;
      end
    endcase
    if (ns == 2 && m_st != 2 && m_cnt < 255) m_cnt = m_cnt + 1;
    m_st = ns;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic f,
                         input logic v, input logic b, input logic [7:0] c);
    chk({tag, ".state"}, {6'd0, alarm_state}, {6'd0, st});
    chk({tag, ".fan"}, {7'd0, fan_on}, {7'd0, f});
    chk({tag, ".valve"}, {7'd0, valve_close}, {7'd0, v});
    chk({tag, ".buzzer"}, {7'd0, buzzer}, {7'd0, b});
    chk({tag, ".count"}, alarm_count, c);
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, 2'(m_st), (m_st == 1 || m_st == 2), (m_st == 2),
            ((m_st == 2 && m_sil == 0) || m_st == 3), 8'(m_cnt));
  endtask

  task automatic step(input logic [2:0] g, input logic a, input logic t, input logic r);
    gas_level = g; ack = a; test_req = t; arst = r;
    @(posedge clk);
    model_step(int'(g), a, t, r);
    #1;
  endtask

  typedef struct {
    logic [2:0] gas;
    logic       ack, treq, rst;
    logic [1:0] st;
    logic       fan, valve, buzz;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic [2:0] g, input logic a, input logic t, input logic r,
                     input logic [1:0] st, input logic f, input logic v, input logic b,
                     input logic [7:0] c);
    vec_t e;
    e.gas = g; e.ack = a; e.treq = t; e.rst = r;
    e.st = st; e.fan = f; e.valve = v; e.buzz = b; e.cnt = c;
    for (int i = 0; i < n; i++) tbl.push_back(e);
  endtask

  initial begin
    // reset, then warn confirm and clear
    add(2,  3'd0, 0, 0, 1, 2'd0, 0, 0, 0, 8'd0);
    add(3,  3'd4, 0, 0, 0, 2'd0, 0, 0, 0, 8'd0);
    add(1,  3'd4, 0, 0, 0, 2'd1, 1, 0, 0, 8'd0);
    add(15, 3'd0, 0, 0, 0, 2'd1, 1, 0, 0, 8'd0);
    add(1,  3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 8'd0);
    // three danger samples are not enough, four are
    add(3,  3'd7, 0, 0, 0, 2'd0, 0, 0, 0, 8'd0);
    add(1,  3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 8'd0);
    add(3,  3'd7, 0, 0, 0, 2'd0, 0, 0, 0, 8'd0);
    add(1,  3'd7, 0, 0, 0, 2'd2, 1, 1, 1, 8'd1);
    // silence then clear
    add(1,  3'd7, 1, 0, 0, 2'd2, 1, 1, 0, 8'd1);
    add(1,  3'd7, 0, 0, 0, 2'd2, 1, 1, 0, 8'd1);
    add(15, 3'd0, 0, 0, 0, 2'd2, 1, 1, 0, 8'd1);
    add(1,  3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 8'd1);
    // escalation wins over a simultaneous test request, at the inclusive warn boundary
    add(3,  3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 8'd1);
    add(1,  3'd3, 0, 1, 0, 2'd1, 1, 0, 0, 8'd1);
    add(15, 3'd2, 0, 0, 0, 2'd1, 1, 0, 0, 8'd1);
    add(1,  3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 8'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].gas, tbl[i].ack, tbl[i].treq, tbl[i].rst);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].fan, tbl[i].valve, tbl[i].buzz, tbl[i].cnt);
    end

    // self-test runs exactly TESTC cycles
    step(3'd0, 0, 1, 0);
    chk_all("test_enter", 2'd3, 0, 0, 1, 8'd1);
    for (int i = 1; i < TESTC; i++) begin
      step(3'd0, 0, 0, 0);
      chk_all($sformatf("test_hold%0d", i), 2'd3, 0, 0, 1, 8'd1);
    end
    step(3'd0, 0, 0, 0);
    chk_all("test_done", 2'd0, 0, 0, 0, 8'd1);

    // self-test aborted by gas in its third cycle
    step(3'd0, 0, 1, 0);
    chk_all("abort_enter", 2'd3, 0, 0, 1, 8'd1);
    step(3'd0, 0, 0, 0);
    step(3'd0, 0, 0, 0);
    chk_all("abort_c2", 2'd3, 0, 0, 1, 8'd1);
    step(3'd5, 0, 0, 0);
    chk_all("abort_exit", 2'd0, 0, 0, 0, 8'd1);
    step(3'd0, 0, 0, 0);
    chk_all("abort_after", 2'd0, 0, 0, 0, 8'd1);

    // ack outside ALARM is ignored; danger boundary level 6; reset mid-ALARM
    step(3'd0, 1, 0, 0);
    for (int i = 0; i < CONFIRM; i++) step(3'd6, 0, 0, 0);
    chk_all("danger6_alarm", 2'd2, 1, 1, 1, 8'd2);
    step(3'd6, 0, 0, 1);
    chk_all("rst_in_alarm", 2'd0, 0, 0, 0, 8'd0);
    step(3'd0, 0, 0, 0);
    chk_all("rst_after", 2'd0, 0, 0, 0, 8'd0);

    // alternating danger/clean never confirms
    for (int i = 0; i < 40; i++) begin
      step((i % 2 == 0) ? 3'd7 : 3'd0, 0, 0, 0);
      chk({"alt.state"}, {6'd0, alarm_state}, 8'd0);
      chk({"alt.count"}, alarm_count, 8'd0);
    end

    // alarm_count saturates at 255
    for (int n = 1; n <= 256; n++) begin
      for (int i = 0; i < CONFIRM; i++) step(3'd7, 0, 0, 0);
      if (n >= 255) chk($sformatf("sat_cnt%0d", n), alarm_count, 8'd255);
      step(3'd7, 1, 0, 0);
      for (int i = 0; i < CLEAR; i++) step(3'd0, 0, 0, 0);
    end
    chk_model("sat_end");

    // randomized traffic against the reference model
    step(3'd0, 0, 0, 1);
    begin
      logic [2:0] g;
      g = 3'd0;
      for (int i = 0; i < 3000; i++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2) g = 3'($urandom_range(0, 2));
        else if (r < 4) g = 3'($urandom_range(3, 7));
        step(g, ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 599) == 0));
        chk_model($sformatf("rnd%0d", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
